// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds an external 1-bit ALU slice one operand
// bit per cycle (LSB first) and assembles the result word and flags.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_a, in_b, in_op     operands and opcode (00 add, 01 sub, 10 cmp, 11 and)
//   out_valid/out_ready   result handshake
//   out_res               result word
//   out_c, out_z, out_n   carry, zero, negative/less-than flags
//   alu_a .. alu_m1       drive to the external slice
//   alu_f, alu_cout, alu_n  slice outputs
module alu_serial_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_c,
   output logic             out_z,
   output logic             out_n,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   output logic             alu_m0,
   output logic             alu_m1,
   input  logic             alu_f,
   input  logic             alu_cout,
   input  logic             alu_n
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic [1:0]       op_reg;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             gt;
   logic             lt;

   logic             last;
   logic             is_cmp;
   logic             is_arith;
   logic             eq;
   logic [WIDTH-1:0] res_word;

   assign last     = (cnt == CW'(WIDTH - 1));
   assign is_cmp   = (op_reg == OP_CMP);
   assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);
   assign eq       = ~gt & ~lt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         op_reg  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         gt      <= 1'b0;
         lt      <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            op_reg  <= in_op;
            res_reg <= '0;
            cnt     <= '0;
            // sub starts with carry=1 so the slice sees a + ~b + 1
            carry   <= (in_op == OP_SUB);
            gt      <= 1'b0;
            lt      <= 1'b0;
         end
      end else if (state == RUN) begin
         cnt <= cnt + 1'b1;
         if (is_arith) begin
            carry <= alu_cout;
         end
         if (!is_cmp) begin
            res_reg[cnt] <= alu_f;
         end else if (!alu_f) begin
            // later (more significant) differing bits overwrite earlier ones
            gt <= alu_cout;
            lt <= alu_n;
         end
      end
   end

   always_comb begin
      alu_a   = 1'b0;
      alu_b   = 1'b0;
      alu_cin = 1'b0;
      alu_m0  = 1'b0;
      alu_m1  = 1'b0;
      if (state == RUN) begin
         alu_a  = a_reg[cnt];
         alu_b  = b_reg[cnt];
         alu_m0 = op_reg[0];
         alu_m1 = op_reg[1];
         // the slice inverts Cin in sub mode, so present ~carry there
         if (op_reg == OP_ADD) begin
            alu_cin = carry;
         end else if (op_reg == OP_SUB) begin
            alu_cin = ~carry;
         end
      end
   end

   always_comb begin
      res_word = res_reg;
      if (is_cmp) begin
         res_word    = '0;
         res_word[0] = eq;
         if (WIDTH > 1) res_word[1 % WIDTH] = gt;
         if (WIDTH > 2) res_word[2 % WIDTH] = lt;
      end
   end

   always_comb begin
      out_res = '0;
      out_c   = 1'b0;
      out_z   = 1'b0;
      out_n   = 1'b0;
      if (state == DONE) begin
         out_res = res_word;
         out_c   = is_arith & carry;
         out_z   = is_cmp ? eq : (res_reg == '0);
         out_n   = is_cmp ? lt : res_reg[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq with a behavioural 1-bit slice.
// Ports: none (top-level bench).
module tb_alu_serial_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [1:0]   in_op = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_res;
   logic         out_c, out_z, out_n;
   logic         alu_a, alu_b, alu_cin, alu_m0, alu_m1;
   logic         alu_f, alu_cout, alu_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res),
      .out_c(out_c), .out_z(out_z), .out_n(out_n),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_m0(alu_m0), .alu_m1(alu_m1),
      .alu_f(alu_f), .alu_cout(alu_cout), .alu_n(alu_n)
   );

   // external 1-bit slice; in sub mode it uses ~b and ~cin
   always_comb begin
      logic bb, cc;
      alu_f    = 1'b0;
      alu_cout = 1'b0;
      alu_n    = 1'b0;
      bb       = alu_b;
      cc       = alu_cin;
      case ({alu_m1, alu_m0})
         2'b00, 2'b01: begin
            if (alu_m0) begin
               bb = ~alu_b;
               cc = ~alu_cin;
            end
            alu_f    = alu_a ^ bb ^ cc;
            alu_cout = (alu_a & bb) | (alu_a & cc) | (bb & cc);
         end
         2'b10: begin
            alu_f    = (alu_a == alu_b);
            alu_cout = alu_a & ~alu_b;
            alu_n    = ~alu_a & alu_b;
         end
         default: alu_f = alu_a & alu_b;
      endcase
   end

   // word-level reference: {n, z, c, res}
   function automatic logic [W+2:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [1:0] op);
      logic [W-1:0] r;
      logic c, z, n;
      int ia, ib;
      ia = int'(a);
      ib = int'(b);
      c  = 1'b0;
      case (op)
         2'b00: begin
            r = W'(ia + ib);
            c = (ia + ib) >= (1 << W);
         end
         2'b01: begin
            r = W'(ia - ib);
            c = (ia >= ib);
         end
         2'b10: begin
            if (ia == ib)     r = W'(1);
            else if (ia > ib) r = W'(2);
            else              r = W'(4);
         end
         default: r = a & b;
      endcase
      z = (r == '0);
      n = r[W-1];
      if (op == 2'b10) begin
         z = (ia == ib);
         n = (ia < ib);
      end
      return {n, z, c, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: rdy=%b vld=%b want 1 0", in_ready, out_valid);
      end
      checks++;
      if ({out_res, out_c, out_z, out_n} !== '0) begin
         errors++;
         $display("FAIL reset_out: res=%b c%b z%b n%b want 0",
                  out_res, out_c, out_z, out_n);
      end
      checks++;
      if ({alu_a, alu_b, alu_cin, alu_m0, alu_m1} !== 5'b0) begin
         errors++;
         $display("FAIL reset_pins: %b want 00000",
                  {alu_a, alu_b, alu_cin, alu_m0, alu_m1});
      end
      rst = 1'b0;
      tick();
   endtask

   // one full transaction; hold = cycles with out_ready low in DONE
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input int hold);
      logic [W+2:0] exp;
      int lat;
      exp = model(a, b, op);
      lat = 0;
      in_a = a;
      in_b = b;
      in_op = op;
      in_valid = 1'b1;
      out_ready = (hold == 0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_ready: got %b want 1", in_ready);
      end
      for (int e = 1; e <= W + 4; e++) begin
         tick();
         if (e == 1) begin
            in_valid = 1'b0;
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_op = 2'($urandom);
         end
         if (out_valid === 1'b1) begin
            lat = e;
            break;
         end
         if (e <= W) begin
            checks++;
            if ({alu_m1, alu_m0} !== op || alu_a !== a[e-1] ||
                alu_b !== b[e-1] || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL run_pins k=%0d: m=%b a=%b b=%b rdy=%b want m=%b a=%b b=%b rdy=0",
                        e - 1, {alu_m1, alu_m0}, alu_a, alu_b, in_ready,
                        op, a[e-1], b[e-1]);
            end
         end
      end
      checks++;
      if (lat != W + 1) begin
         errors++;
         $display("FAIL latency: got %0d want %0d", lat, W + 1);
      end
      for (int h = 0; h <= hold; h++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {out_n, out_z, out_c, out_res} !== exp) begin
            errors++;
            $display("FAIL result op=%b a=%0d b=%0d h=%0d: vld=%b rdy=%b nzc=%b%b%b res=%b want nzc=%b res=%b",
                     op, a, b, h, out_valid, in_ready, out_n, out_z, out_c,
                     out_res, exp[W+2:W], exp[W-1:0]);
         end
         if (h == hold) break;
         tick();
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          {alu_a, alu_b, alu_cin, alu_m0, alu_m1} !== 5'b0) begin
         errors++;
         $display("FAIL release: vld=%b rdy=%b pins=%b want 0 1 00000",
                  out_valid, in_ready, {alu_a, alu_b, alu_cin, alu_m0, alu_m1});
      end
   endtask

   task automatic test_directed();
      do_op(4'd9, 4'd8, 2'b00, 0);
      do_op(4'd3, 4'd5, 2'b01, 0);
      do_op(4'd5, 4'd5, 2'b01, 0);
      do_op(4'd6, 4'd5, 2'b10, 0);
      do_op(4'd4, 4'd9, 2'b10, 0);
      do_op(4'd7, 4'd7, 2'b10, 0);
      do_op(4'd12, 4'd10, 2'b11, 3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_op(W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_reset_abort();
      in_a = 4'd15;
      in_b = 4'd1;
      in_op = 2'b00;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== '0) begin
         errors++;
         $display("FAIL abort: rdy=%b vld=%b res=%b want 1 0 0000",
                  in_ready, out_valid, out_res);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_ghost: vld=%b want 0 at %0d", out_valid, i);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W+2:0] e1, e2;
      e1 = model(4'd10, 4'd7, 2'b01);
      e2 = model(4'd3, 4'd11, 2'b10);
      out_ready = 1'b1;
      in_a = 4'd10;
      in_b = 4'd7;
      in_op = 2'b01;
      in_valid = 1'b1;
      tick();
      in_a = 4'd3;
      in_b = 4'd11;
      in_op = 2'b10;
      for (int e = 2; e <= 12; e++) begin
         tick();
         if (e == 5) begin
            checks++;
            if (out_valid !== 1'b1 || {out_n, out_z, out_c, out_res} !== e1) begin
               errors++;
               $display("FAIL b2b_first: vld=%b res=%b want 1 %b",
                        out_valid, {out_n, out_z, out_c, out_res}, e1);
            end
         end else if (e == 6) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
                {alu_m1, alu_m0} !== 2'b00) begin
               errors++;
               $display("FAIL b2b_gap: vld=%b rdy=%b m=%b want 0 1 00",
                        out_valid, in_ready, {alu_m1, alu_m0});
            end
         end else if (e == 7) begin
            checks++;
            if (in_ready !== 1'b0 || {alu_m1, alu_m0} !== 2'b10) begin
               errors++;
               $display("FAIL b2b_accept: rdy=%b m=%b want 0 10",
                        in_ready, {alu_m1, alu_m0});
            end
            in_valid = 1'b0;
         end else if (e == 11) begin
            checks++;
            if (out_valid !== 1'b1 || {out_n, out_z, out_c, out_res} !== e2) begin
               errors++;
               $display("FAIL b2b_second: vld=%b res=%b want 1 %b",
                        out_valid, {out_n, out_z, out_c, out_res}, e2);
            end
         end else if (e == 12) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_end: rdy=%b vld=%b want 1 0",
                        in_ready, out_valid);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_reset_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
